// File: rtl/sdp_ew_alu_unpack.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ew_alu_unpack
// Purpose  : Splits each 257-bit ERDMA ALU operand entry (256 data bits plus
//            a layer_end flag) into NBEAT = 256/OUT_DW beats of OUT_DW bits.
//            Beat 0 carries the LSBs. The layer_end flag appears only on the
//            final beat of its entry.
//            Optional stall performance counter: define SDP_EW_UNPACK_PERF_EN.
// Ports    : nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//            op_load                            layer start pulse (perf only)
//            sdp_erdma2dp_alu_valid/ready/pd    257-bit upstream operand
//            alu_beat_valid/ready/pd            OUT_DW+1 bit beat to SDP ALU
//            layer_done                         pulse after last beat of layer
//            dp2reg_alu_unpack_stall            stall cycle count
// Revision : 1.0  initial release
// ============================================================================
module sdp_ew_alu_unpack #(
    parameter int OUT_DW = 128
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              op_load,
    input  logic              sdp_erdma2dp_alu_valid,
    output logic              sdp_erdma2dp_alu_ready,
    input  logic [256:0]      sdp_erdma2dp_alu_pd,
    output logic              alu_beat_valid,
    input  logic              alu_beat_ready,
    output logic [OUT_DW:0]   alu_beat_pd,
    output logic              layer_done,
    output logic [31:0]       dp2reg_alu_unpack_stall
);

    localparam int NBEAT = 256 / OUT_DW;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    logic [256:0]   entry;
    logic [BW-1:0]  beat;
    logic           full;
    logic           layer_done_r;

    logic           in_xfer;
    logic           beat_xfer;
    logic           final_xfer;
    logic           last_flag;

    // Entry data viewed as an array of beat slices; element 0 holds the LSBs.
    logic [NBEAT-1:0][OUT_DW-1:0] slices;

    assign slices     = entry[255:0];
    assign beat_xfer  = full & alu_beat_ready;
    assign final_xfer = beat_xfer & (beat == LAST_BEAT);
    assign last_flag  = entry[256] & (beat == LAST_BEAT);

    // Accepting a new entry on the cycle the final beat leaves keeps the
    // beat stream contiguous across entries.
    assign sdp_erdma2dp_alu_ready = ~full | final_xfer;
    assign in_xfer                = sdp_erdma2dp_alu_valid & sdp_erdma2dp_alu_ready;

    assign alu_beat_valid = full;
    assign alu_beat_pd    = {last_flag, slices[beat]};
    assign layer_done     = layer_done_r;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            entry        <= '0;
            beat         <= '0;
            full         <= 1'b0;
            layer_done_r <= 1'b0;
        end else begin
            layer_done_r <= beat_xfer & last_flag;
            if (in_xfer) begin
                // A load in the same cycle as the final beat wins.
                entry <= sdp_erdma2dp_alu_pd;
                full  <= 1'b1;
                beat  <= '0;
            end else if (final_xfer) begin
                full  <= 1'b0;
                beat  <= '0;
            end else if (beat_xfer) begin
                beat  <= beat + 1'b1;
            end
        end
    end

`ifdef SDP_EW_UNPACK_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt <= '0;
        end else if (op_load) begin
            stall_cnt <= '0;
        end else if (full && !alu_beat_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign dp2reg_alu_unpack_stall = stall_cnt;
`else
    // op_load only feeds the stall counter, which is absent in this build.
    logic unused_op_load;
    assign unused_op_load          = op_load;
    assign dp2reg_alu_unpack_stall = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_ew_alu_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ew_alu_unpack
// Purpose  : Directed self-checking bench. One instance uses OUT_DW=128 and a
//            second instance uses OUT_DW=64. Both share clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdp_ew_alu_unpack;

    logic clk;
    logic rstn;

    // OUT_DW = 128 instance
    logic         a_op_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done;
    logic [256:0] a_in_pd;
    logic [128:0] a_out_pd;
    logic [31:0]  a_stall;

    // OUT_DW = 64 instance
    logic         b_op_load, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
    logic [256:0] b_in_pd;
    logic [64:0]  b_out_pd;
    logic [31:0]  b_stall;

    int n_chk;
    int n_err;

`ifdef SDP_EW_UNPACK_PERF_EN
    localparam int EXP_STALL = 2;
`else
    localparam int EXP_STALL = 0;
`endif

    sdp_ew_alu_unpack #(.OUT_DW(128)) u_dut_a (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .op_load                 (a_op_load),
        .sdp_erdma2dp_alu_valid  (a_in_valid),
        .sdp_erdma2dp_alu_ready  (a_in_ready),
        .sdp_erdma2dp_alu_pd     (a_in_pd),
        .alu_beat_valid          (a_out_valid),
        .alu_beat_ready          (a_out_ready),
        .alu_beat_pd             (a_out_pd),
        .layer_done              (a_done),
        .dp2reg_alu_unpack_stall (a_stall)
    );

    sdp_ew_alu_unpack #(.OUT_DW(64)) u_dut_b (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .op_load                 (b_op_load),
        .sdp_erdma2dp_alu_valid  (b_in_valid),
        .sdp_erdma2dp_alu_ready  (b_in_ready),
        .sdp_erdma2dp_alu_pd     (b_in_pd),
        .alu_beat_valid          (b_out_valid),
        .alu_beat_ready          (b_out_ready),
        .alu_beat_pd             (b_out_pd),
        .layer_done              (b_done),
        .dp2reg_alu_unpack_stall (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [256:0] act, input logic [256:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] d0, d1, d2, d3, d4;
    logic [255:0] ent [4];

    initial begin
        int j, k, cyc, first, last;
        logic [128:0] exp_a;
        logic [64:0]  exp_b;

        n_chk = 0;
        n_err = 0;
        d0 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        d1 = {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_C0DE_1234_5678};
        d2 = {64'hCCCC_0000_CCCC_0000, 64'h3333_FFFF_3333_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
        d3 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        d4 = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222, 64'hAAAA_BBBB_CCCC_DDDD, 64'hEEEE_FFFF_0000_1111};
        for (int i = 0; i < 4; i++) ent[i] = {4{32'h1000_0000 * (i + 1) + 32'h0000_00A0 + i}};

        rstn = 1'b1;
        a_op_load = 1'b0; a_in_valid = 1'b0; a_in_pd = '0; a_out_ready = 1'b1;
        b_op_load = 1'b0; b_in_valid = 1'b0; b_in_pd = '0; b_out_ready = 1'b1;
        #2 rstn = 1'b0;
        #2;
        // ---------------- reset state ----------------
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_ready", a_in_ready, 1);
        chk("rst_a_pd",    a_out_pd, 0);
        chk("rst_a_done",  a_done, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_ready", b_in_ready, 1);
        chk("rst_b_pd",    b_out_pd, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // ---------------- single entry, 128-bit beats ----------------
        a_in_valid = 1'b1; a_in_pd = {1'b0, d0};
        #1 chk("single_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        #1;
        chk("single_valid0", a_out_valid, 1);
        chk("single_beat0",  a_out_pd, {1'b0, d0[127:0]});
        chk("single_rdy0",   a_in_ready, 0);
        tick();
        #1;
        chk("single_beat1",  a_out_pd, {1'b0, d0[255:128]});
        chk("single_done1",  a_done, 0);
        tick();
        #1;
        chk("single_idle",   a_out_valid, 0);
        chk("single_nodone", a_done, 0);
        tick();

        // ---------------- four back-to-back entries ----------------
        j = 0; k = 0; cyc = 0; first = -1; last = 0;
        while (j < 8 && cyc < 40) begin
            a_in_valid = (k < 4);
            a_in_pd    = {1'b0, ent[k % 4]};
            #1;
            if (a_out_valid) begin
                exp_a = {1'b0, ent[j / 2][(j % 2) * 128 +: 128]};
                chk("b2b_beat", a_out_pd, exp_a);
                if (j % 2 == 1) chk("b2b_in_ready", a_in_ready, 1);
                if (first < 0) first = cyc;
                last = cyc;
                j++;
            end
            if (a_in_valid && a_in_ready) k++;
            tick();
            cyc++;
        end
        a_in_valid = 1'b0;
        chk("b2b_count",  j, 8);
        chk("b2b_loaded", k, 4);
        chk("b2b_contig", last - first, 7);
        #1 chk("b2b_idle", a_out_valid, 0);
        tick();

        // ---------------- layer end flag and layer_done ----------------
        a_in_valid = 1'b1; a_in_pd = {1'b1, d1};
        tick();
        a_in_valid = 1'b0;
        #1;
        chk("le_beat0", a_out_pd, {1'b0, d1[127:0]});
        chk("le_done0", a_done, 0);
        tick();
        #1;
        chk("le_beat1", a_out_pd, {1'b1, d1[255:128]});
        chk("le_done1", a_done, 0);
        tick();
        #1;
        chk("le_done_pulse", a_done, 1);
        chk("le_idle",       a_out_valid, 0);
        tick();
        #1 chk("le_done_clear", a_done, 0);
        tick();

        // ---------------- stall hold and stall counter ----------------
        a_op_load = 1'b1;
        tick();
        a_op_load = 1'b0;
        #1 chk("stall_clear0", a_stall, 0);
        a_in_valid = 1'b1; a_in_pd = {1'b0, d2};
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        #1 chk("stall_beat0", a_out_pd, {1'b0, d2[127:0]});
        tick();
        a_out_ready = 1'b0;
        #1 chk("stall_hold1", a_out_pd, {1'b0, d2[255:128]});
        tick();
        #1;
        chk("stall_hold2", a_out_pd, {1'b0, d2[255:128]});
        chk("stall_valid", a_out_valid, 1);
        tick();
        a_out_ready = 1'b1;
        #1;
        chk("stall_hold3", a_out_pd, {1'b0, d2[255:128]});
        chk("stall_count", a_stall, EXP_STALL);
        tick();
        #1;
        chk("stall_idle",  a_out_valid, 0);
        chk("stall_kept",  a_stall, EXP_STALL);
        a_op_load = 1'b1;
        tick();
        a_op_load = 1'b0;
        #1 chk("stall_clear", a_stall, 0);
        tick();

        // ---------------- 64-bit beats ----------------
        b_in_valid = 1'b1; b_in_pd = {1'b1, d3};
        #1 chk("w64_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_b = {(i == 3) ? 1'b1 : 1'b0, d3[i * 64 +: 64]};
            chk("w64_beat", b_out_pd, exp_b);
            chk("w64_valid", b_out_valid, 1);
            chk("w64_nodone", b_done, 0);
            tick();
        end
        #1;
        chk("w64_done",  b_done, 1);
        chk("w64_idle",  b_out_valid, 0);
        tick();
        #1 chk("w64_done_clear", b_done, 0);
        tick();

        // ---------------- async reset mid-entry ----------------
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_pd = {1'b1, d4};
        tick();
        a_in_valid = 1'b0;
        #1 chk("rmid_beat0", a_out_pd, {1'b0, d4[127:0]});
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        #1;
        chk("rmid_beat1", a_out_pd, {1'b1, d4[255:128]});
        chk("rmid_full",  a_out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("rmid_valid", a_out_valid, 0);
        chk("rmid_ready", a_in_ready, 1);
        chk("rmid_pd",    a_out_pd, 0);
        tick();
        tick();
        rstn = 1'b0;
        #1 rstn = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rmid_nodone", a_done, 0);
            chk("rmid_idle",   a_out_valid, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
